// File: rtl/note_player_pkg.sv
// note_player_pkg: shared widths, note/state codes and the small arithmetic
// helpers used by the buzzer note player.
//   - OCTAVE/NOTE/LENGTH_BITS : widths of the sampled request fields
//   - HALF_BITS               : half-period counter width (covers low C 382220)
//   - ST_*                    : sequencer state encodings
//   - units_of()              : length code -> duration units (64 >> length)
//   - octave_half()           : mid-octave half period -> octave/scale adjusted
package note_player_pkg;

  localparam int OCTAVE_BITS = 2;
  localparam int NOTE_BITS   = 3;
  localparam int LENGTH_BITS = 3;
  localparam int HALF_BITS   = 20;
  localparam int MAX_UNITS   = 64;
  localparam int UNIT_BITS   = 7;

  localparam logic [NOTE_BITS-1:0] NOTE_REST = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Length code 7 is clamped to 6 so the shortest note is one unit.
  function automatic logic [UNIT_BITS-1:0] units_of(input logic [LENGTH_BITS-1:0] length);
    logic [LENGTH_BITS-1:0] len_s;
    len_s = (length == 3'd7) ? 3'd6 : length;
    return 7'd64 >> len_s;
  endfunction

  // Low octave doubles, high halves (octave 3 behaves as high), then the
  // simulation scale shift; the result never drops below one cycle.
  function automatic logic [HALF_BITS-1:0] octave_half(input logic [HALF_BITS-1:0] mid,
                                                       input logic [OCTAVE_BITS-1:0] octave,
                                                       input int unsigned shift);
    logic [HALF_BITS:0] wide_s;
    case (octave)
      2'd0:    wide_s = {mid, 1'b0};
      2'd1:    wide_s = {1'b0, mid};
      default: wide_s = {2'b00, mid[HALF_BITS-1:1]};
    endcase
    wide_s = wide_s >> shift;
    if (wide_s == '0) begin
      wide_s = 21'd1;
    end
    return wide_s[HALF_BITS-1:0];
  endfunction

endpackage

// File: rtl/note_player_if.sv
// note_player_if: request/status bundle between the key-hit stage (master)
// and the note player (slave).
//   start/stop              : one-cycle play request / abort
//   octave/note/length      : note description sampled with start
//   buzzer/busy/done        : square wave, activity flag, completion pulse
interface note_player_if;
  import note_player_pkg::*;

  logic                   start;
  logic                   stop;
  logic [OCTAVE_BITS-1:0] octave;
  logic [NOTE_BITS-1:0]   note;
  logic [LENGTH_BITS-1:0] length;
  logic                   buzzer;
  logic                   busy;
  logic                   done;

  modport master (output start, stop, octave, note, length,
                  input  buzzer, busy, done);

  modport slave  (input  start, stop, octave, note, length,
                  output buzzer, busy, done);

endinterface

// File: rtl/note_player_tone_rom.sv
// note_player_tone_rom: combinational lookup of the mid-octave half period
// (in 100 MHz cycles) for notes C..B; the rest code returns 0.
//   note : note code 0..7
//   half : mid-octave half period
module note_player_tone_rom
  import note_player_pkg::*;
(
  input  logic [NOTE_BITS-1:0] note,
  output logic [HALF_BITS-1:0] half
);

  // Pitch table
  always_comb begin
    case (note)
      3'd0:    half = 20'd191110;
      3'd1:    half = 20'd170265;
      3'd2:    half = 20'd151685;
      3'd3:    half = 20'd143172;
      3'd4:    half = 20'd127551;
      3'd5:    half = 20'd113636;
      3'd6:    half = 20'd101239;
      default: half = 20'd0;
    endcase
  end

endmodule

// File: rtl/note_player.sv
// note_player: plays one sampled note on the buzzer as a square wave for
// (64 >> length) * UNIT_CYCLES cycles, then stays silent for GAP_CYCLES,
// then pulses done. stop aborts at the next edge without a done pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : note_player_if.slave (start/stop/octave/note/length in,
//                buzzer/busy/done out, all outputs registered)
module note_player
  import note_player_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 1_562_500,
  parameter int unsigned GAP_CYCLES  = 5_000_000,
  parameter int unsigned HALF_SHIFT  = 0
) (
  input logic          clk,
  input logic          rst_n,
  note_player_if.slave bus
);

  localparam int PRE_BITS = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int GAP_BITS = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PRE_BITS-1:0] PRE_LAST = PRE_BITS'(UNIT_CYCLES - 1);
  localparam logic [GAP_BITS-1:0] GAP_LAST = GAP_BITS'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (GAP_CYCLES != 0);

  logic [1:0]           state_r;
  logic                 buzzer_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 rest_r;
  logic [PRE_BITS-1:0]  pre_r;
  logic [UNIT_BITS-1:0] units_r;
  logic [GAP_BITS-1:0]  gap_r;
  logic [HALF_BITS-1:0] half_r;
  logic [HALF_BITS-1:0] half_cnt_r;

  logic [HALF_BITS-1:0] rom_half_s;
  logic [HALF_BITS-1:0] start_half_s;
  logic                 play_end_s;
  logic                 gap_end_s;
  logic                 tone_edge_s;

  note_player_tone_rom u_rom (
    .note (bus.note),
    .half (rom_half_s)
  );

  // Expiry and toggle conditions for the current cycle
  always_comb begin
    start_half_s = octave_half(rom_half_s, bus.octave, HALF_SHIFT);
    // Last cycle of the last unit: the prescaler wraps with one unit left.
    play_end_s   = (pre_r == PRE_LAST) && (units_r == 7'd1);
    gap_end_s    = (gap_r == GAP_LAST);
    tone_edge_s  = ((half_cnt_r + HALF_BITS'(1)) == half_r);
  end

  // Sequencer: latches the note on start, times PLAY and GAP, drives outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      buzzer_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rest_r     <= 1'b0;
      pre_r      <= '0;
      units_r    <= '0;
      gap_r      <= '0;
      half_r     <= '0;
      half_cnt_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          buzzer_r <= 1'b0;
          // stop outranks start even while idle
          if (bus.start && !bus.stop) begin
            state_r    <= ST_PLAY;
            busy_r     <= 1'b1;
            pre_r      <= '0;
            units_r    <= units_of(bus.length);
            half_r     <= start_half_s;
            half_cnt_r <= '0;
            rest_r     <= (bus.note == NOTE_REST);
          end
        end
        ST_PLAY: begin
          if (bus.stop) begin
            state_r    <= ST_IDLE;
            buzzer_r   <= 1'b0;
            busy_r     <= 1'b0;
            pre_r      <= '0;
            units_r    <= '0;
            half_cnt_r <= '0;
          end else if (play_end_s) begin
            buzzer_r   <= 1'b0;
            pre_r      <= '0;
            units_r    <= '0;
            half_cnt_r <= '0;
            if (HAS_GAP) begin
              state_r <= ST_GAP;
              gap_r   <= '0;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end else begin
            if (pre_r == PRE_LAST) begin
              pre_r   <= '0;
              units_r <= units_r - 7'd1;
            end else begin
              pre_r <= pre_r + PRE_BITS'(1);
            end
            // Rests run the same counter but never let the buzzer rise.
            if (tone_edge_s) begin
              half_cnt_r <= '0;
              buzzer_r   <= ~buzzer_r & ~rest_r;
            end else begin
              half_cnt_r <= half_cnt_r + HALF_BITS'(1);
            end
          end
        end
        ST_GAP: begin
          buzzer_r <= 1'b0;
          if (bus.stop) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            gap_r   <= '0;
          end else if (gap_end_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            gap_r   <= '0;
          end else begin
            gap_r <= gap_r + GAP_BITS'(1);
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          buzzer_r <= 1'b0;
          busy_r   <= 1'b0;
          gap_r    <= '0;
        end
      endcase
    end
  end

  assign bus.buzzer = buzzer_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;

endmodule

// File: tb/tb_note_player.sv
// tb_note_player: drives note_player (UNIT_CYCLES=10, GAP_CYCLES=4,
// HALF_SHIFT=10) with directed and random requests. A behavioural model
// predicts buzzer/busy/done from elapsed time since the accepted start and
// is compared against the DUT after every clock edge; directed runs also
// pin absolute timings and toggle intervals to hand-computed numbers.
module tb_note_player;

  localparam int UNIT = 10;
  localparam int GAP  = 4;
  localparam int HS   = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  note_player_if bus ();

  note_player #(
    .UNIT_CYCLES (UNIT),
    .GAP_CYCLES  (GAP),
    .HALF_SHIFT  (HS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int mid_tab [7] = '{191110, 170265, 151685, 143172, 127551, 113636, 101239};

  task automatic check_bit(input string name, input logic act, input logic exp, input int when);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s at edge %0d: got %0b, expected %0b", name, when, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_half(input int oct, input int nt);
    int o, h;
    o = (oct > 2) ? 2 : oct;
    h = (o == 0) ? mid_tab[nt] * 2 : (o == 1) ? mid_tab[nt] : mid_tab[nt] / 2;
    h = h >> HS;
    return (h < 1) ? 1 : h;
  endfunction

  // Reference model and per-edge comparison.
  initial begin : model
    int  n, t0, el, m_half, m_u, m_d, l;
    bit  m_busy, m_rest, e_buz, e_busy, e_done;
    n = 0; t0 = 0; m_half = 1; m_u = 0; m_d = 0;
    m_busy = 1'b0; m_rest = 1'b0; e_buz = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    forever begin
      @(posedge clk);
      n++;
      if (!rst_n) begin
        m_busy = 1'b0; e_buz = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      end else if (m_busy) begin
        if (bus.stop) begin
          m_busy = 1'b0; e_buz = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        end else begin
          el = n - t0;
          if (el >= m_d) begin
            m_busy = 1'b0; e_buz = 1'b0; e_busy = 1'b0; e_done = 1'b1;
          end else begin
            e_busy = 1'b1; e_done = 1'b0;
            e_buz  = (!m_rest && el < m_u) ? (((el / m_half) % 2) == 1) : 1'b0;
          end
        end
      end else begin
        e_done = 1'b0; e_buz = 1'b0; e_busy = 1'b0;
        if (bus.start && !bus.stop) begin
          m_busy = 1'b1; e_busy = 1'b1; t0 = n;
          m_rest = (bus.note == 3'd7);
          m_half = (bus.note == 3'd7) ? 1 : model_half(int'(bus.octave), int'(bus.note));
          l      = (bus.length == 3'd7) ? 6 : int'(bus.length);
          m_u    = (64 >> l) * UNIT;
          m_d    = m_u + GAP;
        end
      end
      #2;
      check_bit("buzzer", bus.buzzer, e_buz, n);
      check_bit("busy", bus.busy, e_busy, n);
      check_bit("done", bus.done, e_done, n);
    end
  end

  // Starts a note at the next edge T (caller is just past a negedge) and
  // follows it; k counts edges after T. start2_k / stop_k inject a pulse
  // sampled at edge T+k+1. Returns the first k with busy low and first toggle.
  task automatic play_note(input int oct, input int nt, input int len,
                           input int start2_k, input int stop_k,
                           output int end_k, output bit done_seen, output int tog_k);
    bus.octave = 2'(oct); bus.note = 3'(nt); bus.length = 3'(len);
    bus.start = 1'b1; bus.stop = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    end_k = -1; done_seen = 1'b0; tog_k = -1;
    for (int k = 0; k < 5000; k++) begin
      if (bus.buzzer && tog_k < 0) tog_k = k;
      if (k > 0 && !bus.busy) begin
        end_k = k; done_seen = bus.done;
        break;
      end
      bus.start  = (k == start2_k);
      bus.stop   = (k == stop_k);
      bus.octave = 2'($urandom);
      bus.note   = 3'($urandom);
      bus.length = 3'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0; bus.stop = 1'b0;
  endtask

  initial begin : stim
    int  end_k, tog_k, toggles;
    bit  done_seen;
    logic prev;
    bus.start = 1'b0; bus.stop = 1'b0;
    bus.octave = 2'd0; bus.note = 3'd0; bus.length = 3'd0;

    // Reset, then abort a running note with reset and watch it stay quiet.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.octave = 2'd2; bus.note = 3'd0; bus.length = 3'd0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (150) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    toggles = 0; prev = bus.buzzer;
    check_int("reset_busy", int'(bus.busy), 0);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.buzzer != prev) toggles++;
      prev = bus.buzzer;
    end
    check_int("idle_toggles", toggles, 0);

    // A, mid octave, one unit: no toggle inside 10 PLAY cycles, done at T+14.
    play_note(1, 5, 6, -1, -1, end_k, done_seen, tog_k);
    check_int("timing_end", end_k, 14);
    check_int("timing_done", int'(done_seen), 1);
    check_int("timing_toggle", tog_k, -1);

    // C at each octave, 64 units: first toggle equals the half period.
    play_note(0, 0, 0, -1, -1, end_k, done_seen, tog_k);
    check_int("pitch_low", tog_k, 373);
    check_int("pitch_low_end", end_k, 644);
    play_note(1, 0, 0, -1, -1, end_k, done_seen, tog_k);
    check_int("pitch_mid", tog_k, 186);
    play_note(2, 0, 0, -1, -1, end_k, done_seen, tog_k);
    check_int("pitch_high", tog_k, 93);
    play_note(3, 0, 0, -1, -1, end_k, done_seen, tog_k);
    check_int("pitch_oct3", tog_k, 93);

    // Rest, two units.
    play_note(1, 7, 5, -1, -1, end_k, done_seen, tog_k);
    check_int("rest_end", end_k, 24);
    check_int("rest_toggle", tog_k, -1);

    // Second start sampled at T+3 is ignored.
    play_note(1, 5, 6, 2, -1, end_k, done_seen, tog_k);
    check_int("ignore_end", end_k, 14);

    // stop sampled at T+6: idle at T+6, no done; then a start at T+7.
    play_note(1, 5, 6, -1, 5, end_k, done_seen, tog_k);
    check_int("abort_end", end_k, 6);
    check_int("abort_done", int'(done_seen), 0);
    play_note(1, 5, 6, -1, -1, end_k, done_seen, tog_k);
    check_int("after_abort_end", end_k, 14);
    // Back-to-back: start issued in the done cycle.
    play_note(2, 3, 6, -1, -1, end_k, done_seen, tog_k);
    check_int("b2b_end", end_k, 14);
    check_int("b2b_done", int'(done_seen), 1);

    // Random traffic against the model.
    for (int i = 0; i < 20000; i++) begin
      bus.start  = ($urandom_range(0, 7) == 0);
      bus.stop   = ($urandom_range(0, 99) == 0);
      bus.octave = 2'($urandom);
      bus.note   = 3'($urandom);
      bus.length = 3'($urandom_range(2, 7));
      rst_n      = ($urandom_range(0, 4999) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
